// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg
// Shared definitions for the D-latch write arbiter: the controller state
// encoding and the default number of cycles the latch gate stays open.
// No ports; imported by latch_write_arbiter and rr_pick.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int GATE_CYC_DEFAULT = 2;

endpackage

// File: rtl/latch_write_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search starts at the index
// just after last_owner and wraps from NREQ-1 back to 0, so the most
// recently served requester has the lowest priority.
// Ports:
//   req        - request vector, one bit per requester
//   last_owner - index of the requester served most recently
//   valid      - at least one request is pending
//   idx        - index of the winning requester (0 when valid is low)
module rr_pick
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int cand;

  // Walk the requesters in priority order (last_owner+1 first, last_owner
  // itself last) and keep the first one found with its request raised.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_owner) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
// Shares one external D-latch between NREQ requesters. A winner is chosen
// round-robin in IDLE; its data is registered onto D, then the gate G is
// kept low for one setup cycle, held high for GATE_CYC cycles, and kept low
// for one hold cycle during which the winner receives a one-cycle ack.
// Ports:
//   Clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-high reset
//   req    - per-requester write request (level, held until ack)
//   wdata  - per-requester write data, requester i at [i*W +: W]
//   ack    - one-hot completion pulse during the hold cycle
//   G      - latch gate, driven straight from a flop
//   D      - latch data, stable from grant until the next grant
//   busy   - high whenever a write is in progress
//   owner  - index of the current or last-served requester
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int W        = 1,
  parameter int GATE_CYC = GATE_CYC_DEFAULT,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic              G,
  output logic [W-1:0]      D,
  output logic              busy,
  output logic [IW-1:0]     owner
);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [W-1:0]    d_q, d_d;
  logic            g_q, g_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [W-1:0]    pick_data;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req       (req),
    .last_owner(last_owner_q),
    .valid     (pick_valid),
    .idx       (pick_idx)
  );

  // Route the winning requester's data slice; only used on the grant edge.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_data = wdata[i*W +: W];
      end
    end
  end

  // State register. Reset returns everything to IDLE with the gate shut and
  // last_owner pointing at NREQ-1 so requester 0 has first priority.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      d_q          <= '0;
      g_q          <= 1'b0;
      ack_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      g_q          <= g_d;
      ack_q        <= ack_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic. D and owner are captured only on the IDLE->SETUP edge,
  // so request or data changes later in the write cannot disturb the latch.
  // last_owner moves in HOLD, which is what keeps a requester that never
  // drops req from winning twice while someone else is waiting.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_d          = d_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d = SETUP;
          d_d     = pick_data;
          owner_d = pick_idx;
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = '0;
      end
      OPEN: begin
        if (cnt_q == 4'(GATE_CYC - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        state_d      = IDLE;
        last_owner_d = owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. G and ack are decoded from the upcoming state and then
  // registered, so both are flop outputs aligned with the state they belong to.
  always_comb begin
    g_d   = (state_d == OPEN);
    ack_d = '0;
    if (state_d == HOLD) begin
      for (int i = 0; i < NREQ; i++) begin
        ack_d[i] = (owner_d == IW'(i));
      end
    end
  end

  assign G     = g_q;
  assign D     = d_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter
// Directed bench for latch_write_arbiter with NREQ=4, W=1, GATE_CYC=2.
// A behavioural D-latch sits on G/D so the latched value can be checked.
module tb_latch_write_arbiter;

  logic       Clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] wdata;
  logic [3:0] ack;
  logic       G;
  logic [0:0] D;
  logic       busy;
  logic [1:0] owner;
  logic       latchQ;

  int checkCount;
  int errorCount;

  latch_write_arbiter #(
    .NREQ    (4),
    .W       (1),
    .GATE_CYC(2)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .req  (req),
    .wdata(wdata),
    .ack  (ack),
    .G    (G),
    .D    (D),
    .busy (busy),
    .owner(owner)
  );

  // Clock generation, 10 time-unit period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Transparent-high D-latch standing in for the external latch.
  always @(G or D) begin
    if (G) latchQ = D[0];
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] wd);
    req   = r;
    wdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one full write starting from an IDLE cycle whose req is already set.
  // setupReq is driven onto req once SETUP is reached; toggleData flips the
  // owner's wdata bit before every edge after the grant.
  task automatic runWrite(input string tag, input int expOwner, input logic expD,
                          input logic [3:0] setupReq, input bit toggleData);
    logic [3:0] expAck;
    expAck = 4'b0001 << expOwner;
    tick();
    checkOutput({tag, " setup G"}, G, 1'b0);
    checkOutput({tag, " setup busy"}, busy, 1'b1);
    checkOutput({tag, " setup owner"}, owner, expOwner);
    checkOutput({tag, " setup D"}, D, expD);
    checkOutput({tag, " setup ack"}, ack, 4'b0000);
    req = setupReq;
    for (int k = 0; k < 2; k++) begin
      if (toggleData) wdata[expOwner] = ~wdata[expOwner];
      tick();
      checkOutput({tag, " open G"}, G, 1'b1);
      checkOutput({tag, " open D"}, D, expD);
      checkOutput({tag, " open ack"}, ack, 4'b0000);
      checkOutput({tag, " open Q"}, latchQ, expD);
    end
    if (toggleData) wdata[expOwner] = ~wdata[expOwner];
    tick();
    checkOutput({tag, " hold G"}, G, 1'b0);
    checkOutput({tag, " hold ack"}, ack, expAck);
    checkOutput({tag, " hold D"}, D, expD);
    checkOutput({tag, " hold Q"}, latchQ, expD);
    checkOutput({tag, " hold busy"}, busy, 1'b1);
    tick();
    checkOutput({tag, " idle ack"}, ack, 4'b0000);
    checkOutput({tag, " idle busy"}, busy, 1'b0);
    checkOutput({tag, " idle G"}, G, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000);

    // Reset state.
    tick();
    tick();
    checkOutput("reset G", G, 1'b0);
    checkOutput("reset D", D, 1'b0);
    checkOutput("reset ack", ack, 4'b0000);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset owner", owner, 2'd0);

    // Single write from requester 0.
    reset = 1'b0;
    applyStimulus(4'b0001, 4'b0001);
    runWrite("single", 0, 1'b1, 4'b0001, 1'b0);
    applyStimulus(4'b0000, 4'b0000);

    // Round-robin fairness from a fresh reset: 0,1,2,3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b1010);
    runWrite("rr0", 0, 1'b0, 4'b1111, 1'b0);
    runWrite("rr1", 1, 1'b1, 4'b1111, 1'b0);
    runWrite("rr2", 2, 1'b0, 4'b1111, 1'b0);
    runWrite("rr3", 3, 1'b1, 4'b1111, 1'b0);
    applyStimulus(4'b0000, 4'b0000);

    // Starvation: requester 2 holds req, requester 0 joins mid-write.
    applyStimulus(4'b0100, 4'b0101);
    runWrite("starve a", 2, 1'b1, 4'b0101, 1'b0);
    runWrite("starve b", 0, 1'b1, 4'b0101, 1'b0);
    runWrite("starve c", 2, 1'b1, 4'b0101, 1'b0);
    applyStimulus(4'b0000, 4'b0000);

    // Data stability while the owner's wdata toggles every cycle.
    applyStimulus(4'b0010, 4'b0010);
    runWrite("stable", 1, 1'b1, 4'b0010, 1'b1);
    applyStimulus(4'b0000, 4'b0000);

    // Reset during the second OPEN cycle abandons the write.
    applyStimulus(4'b1000, 4'b1000);
    tick();
    checkOutput("rst setup owner", owner, 2'd3);
    tick();
    checkOutput("rst open1 G", G, 1'b1);
    tick();
    checkOutput("rst open2 G", G, 1'b1);
    reset = 1'b1;
    applyStimulus(4'b1001, 4'b1001);
    tick();
    checkOutput("rst G", G, 1'b0);
    checkOutput("rst ack", ack, 4'b0000);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst owner", owner, 2'd0);
    checkOutput("rst D", D, 1'b0);
    reset = 1'b0;
    runWrite("after rst", 0, 1'b1, 4'b1001, 1'b0);
    applyStimulus(4'b0000, 4'b0000);

    // Request dropped in SETUP still completes with an ack.
    applyStimulus(4'b0010, 4'b0000);
    runWrite("drop", 1, 1'b0, 4'b0000, 1'b0);

    // Idle with no requests holds D and owner with the gate shut.
    applyStimulus(4'b0000, 4'b1111);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("idle G", G, 1'b0);
    checkOutput("idle busy", busy, 1'b0);
    checkOutput("idle D", D, 1'b0);
    checkOutput("idle owner", owner, 2'd1);
    checkOutput("idle ack", ack, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the D-latch; legal values 2..8.
REQ-002 Parameter W, default 1: data width per requester and width of the latch D input.
REQ-003 Parameter GATE_CYC, default 2: cycles G is held high per write; legal values 1..15.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  write request per requester; level, held until ack.
REQ-007 wdata  input  NREQ*W  write data; requester i occupies bits [i*W +: W].
REQ-008 ack  output  NREQ  one-cycle, one-hot completion pulse to the served requester.
REQ-009 G  output  1  gate (enable) to the shared D-latch.
REQ-010 D  output  W  data to the shared D-latch.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 owner  output  clog2(NREQ)  index of the current or last-served requester.

Function
REQ-013 The FSM shall have the states IDLE, SETUP, OPEN and HOLD.
REQ-014 In IDLE with any req bit high, the arbiter shall pick a winner by round-robin, starting from the index after last_owner and wrapping from NREQ-1 to 0, and shall go to SETUP on the next edge.
REQ-015 On the IDLE->SETUP edge, the block shall register the winner's wdata into D and its index into owner; D shall not change again until the next grant.
REQ-016 SETUP shall last exactly 1 cycle with G=0, giving D setup time before the gate opens; next state OPEN.
REQ-017 OPEN shall hold G=1 for exactly GATE_CYC cycles, counted by a 4-bit counter; next state HOLD.
REQ-018 HOLD shall last exactly 1 cycle with G=0 and D unchanged (hold time); ack[owner] shall be 1 in this cycle only; next state IDLE.
REQ-019 Latency from req sampled high in IDLE to ack shall be GATE_CYC+3 cycles; back-to-back writes shall have a minimum period of GATE_CYC+3 cycles, with one IDLE cycle between transactions.
REQ-020 last_owner shall update to owner in HOLD, so a requester that keeps req high cannot win twice in a row while another requester is waiting.
REQ-021 Deasserting req after grant shall not abort the transaction; the write completes and ack still pulses.
REQ-022 Changes to req or wdata during SETUP, OPEN or HOLD shall have no effect on G, D or owner.
REQ-023 With no req high in IDLE, the block shall stay in IDLE with G=0 and D, owner held.
REQ-024 G shall come directly from a flop (glitch-free) and shall never be high outside OPEN.
REQ-025 In all cases, ack shall be one-hot or zero.

Reset
REQ-026 reset high at a clock edge shall force state=IDLE, G=0, D=0, ack=0, busy=0, owner=0, last_owner=NREQ-1 and counter=0, so that requester 0 has first priority.
REQ-027 reset asserted mid-transaction (any state) shall abandon the write with no ack; G shall be 0 from the first edge at which reset is sampled.
REQ-028 reset shall take priority over every other input.

Structure
REQ-029 The state encoding (2-bit IDLE=0, SETUP=1, OPEN=2, HOLD=3) and the default GATE_CYC constant shall live in the shared package latch_ctrl_pkg.
REQ-030 Round-robin winner selection shall be one combinational sub-module, rr_pick (inputs req and last_owner; outputs valid and idx).
REQ-031 The existing Dlatch module shall not be instantiated inside this block; integration connects G and D to it externally.

Verification
REQ-032 Single write: NREQ=4, W=1, GATE_CYC=2, req=0001 with wdata bit0=1 -> SETUP 1 cycle, G high exactly 2 cycles, ack=0001 at cycle 5, and latch Q=1 after the gate closes.
REQ-033 Round-robin fairness: req=1111 held for 4 transactions -> owner sequence 0,1,2,3, with each ack one-hot and matching owner.
REQ-034 Starvation check: req[2] held high continuously and req[0] raised mid-write -> next grant goes to 0, then back to 2.
REQ-035 Data stability: toggle wdata of the owner every cycle during OPEN -> D and latch Q keep the value captured at grant.
REQ-036 Reset mid-OPEN: assert reset in the 2nd OPEN cycle -> G=0 at the next edge, no ack, state=IDLE, and requester 0 wins next.
REQ-037 Request dropped: req deasserted in SETUP -> the write completes and ack still pulses at cycle GATE_CYC+3.
